// File: rtl/eth_txcounters_sn_pkg.sv
// Shared TX MAC constants for the nibble/byte counter stage.
`timescale 1ns/1ps
package eth_txcounters_sn_pkg;

  localparam int NIBCNT_W      = 16;
  localparam int BYTECNT_W     = 16;
  localparam int NIBS_PER_BYTE = 2;

  // Default defer limit, in nibbles, and FCS length, in bytes.
  localparam logic [13:0] EXDFR_LIMIT_DEF = 14'h17B7;
  localparam int          CRC_BYTES_DEF   = 4;

  // Nibble count at which the payload reaches the minimum frame length.
  // The FCS is excluded. The result is 17 bits wide, so 2*0xFFFF cannot overflow.
  function automatic logic [16:0] min_fl_thr(input logic [15:0] min_fl,
                                             input logic [15:0] crc_bytes);
    logic [16:0] payload;
    payload = {1'b0, min_fl} - {1'b0, crc_bytes};
    if (min_fl <= crc_bytes) return '0;
    return payload * 17'(NIBS_PER_BYTE) - 17'd1;
  endfunction

endpackage

// File: rtl/eth_txcounters_sn_if.sv
// Connects the TX state machine and the counter stage.
// The state machine (master) drives the state and strobe inputs.
// The counter stage (slave) returns the counters and flags.
`timescale 1ns/1ps
interface eth_txcounters_sn_if;
  import eth_txcounters_sn_pkg::*;

  logic                 StateIdle;
  logic                 StateIPG;
  logic                 StatePreamble;
  logic [1:0]           StateData;
  logic                 StatePAD;
  logic                 StateFCS;
  logic                 StateJam;
  logic                 StateBackOff;
  logic                 StateDefer;
  logic                 StartDefer;
  logic                 StartIPG;
  logic                 StartFCS;
  logic                 StartJam;
  logic                 StartBackoff;
  logic                 TxStartFrm;
  logic                 PacketFinished_q;
  logic                 ExDfrEn;
  logic                 HugEn;
  logic [15:0]          MinFL;
  logic [15:0]          MaxFL;
  logic [NIBCNT_W-1:0]  NibCnt;
  logic                 NibCntEq7;
  logic                 NibCntEq15;
  logic                 NibbleMinFl;
  logic                 ExcessiveDefer;
  logic [BYTECNT_W-1:0] ByteCnt;
  logic                 MaxFrame;

  modport master (
    output StateIdle, StateIPG, StatePreamble, StateData, StatePAD, StateFCS,
           StateJam, StateBackOff, StateDefer,
           StartDefer, StartIPG, StartFCS, StartJam, StartBackoff,
           TxStartFrm, PacketFinished_q, ExDfrEn, HugEn, MinFL, MaxFL,
    input  NibCnt, NibCntEq7, NibCntEq15, NibbleMinFl, ExcessiveDefer,
           ByteCnt, MaxFrame
  );

  modport slave (
    input  StateIdle, StateIPG, StatePreamble, StateData, StatePAD, StateFCS,
           StateJam, StateBackOff, StateDefer,
           StartDefer, StartIPG, StartFCS, StartJam, StartBackoff,
           TxStartFrm, PacketFinished_q, ExDfrEn, HugEn, MinFL, MaxFL,
    output NibCnt, NibCntEq7, NibCntEq15, NibbleMinFl, ExcessiveDefer,
           ByteCnt, MaxFrame
  );

endinterface

// File: rtl/eth_txcnt_cell.sv
// Generic synchronous up-counter.
// Priority order: reset, then clear, then increment.
// When sat is high, the counter holds at all-ones instead of wrapping.
`timescale 1ns/1ps
module eth_txcnt_cell
  import eth_txcounters_sn_pkg::*;
#(
  parameter int W = NIBCNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         sat,
  output logic [W-1:0] cnt
);

  // Counter register: synchronous reset, then clear, then (optionally saturating) increment.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(sat && (&cnt))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/eth_txcounters_sn.sv
// Nibble and byte counters with comparison flags for the TX state machine.
// Sits in the MTxClk domain.
// The control terms are decoded from State*/Start*.
// The flags are combinational from the two counter registers.
`timescale 1ns/1ps
module eth_txcounters_sn
  import eth_txcounters_sn_pkg::*;
#(
  parameter logic [13:0] EXDFR_LIMIT = EXDFR_LIMIT_DEF,
  parameter int          CRC_BYTES   = CRC_BYTES_DEF
) (
  input  logic                MTxClk,
  input  logic                Reset_n,
  eth_txcounters_sn_if.slave  bus
);

  logic [NIBCNT_W-1:0]  nib_cnt;
  logic [BYTECNT_W-1:0] byte_cnt;
  logic                 nib_eq7;
  logic                 nib_eq15;
  logic                 clr_nib;
  logic                 inc_nib;
  logic                 clr_byte;
  logic                 inc_byte_sat;
  logic                 inc_byte_wrap;
  logic [16:0]          min_thr;

  assign nib_eq7  = &nib_cnt[2:0];
  assign nib_eq15 = &nib_cnt[3:0];

  // Clear/increment decode for both counters. Multiple state inputs OR together literally.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    clr_nib       = 1'b0;
    inc_nib       = 1'b0;
    clr_byte      = 1'b0;
    inc_byte_sat  = 1'b0;
    inc_byte_wrap = 1'b0;

    clr_nib = bus.StateIdle
            | (bus.StateDefer & bus.ExDfrEn & ~bus.TxStartFrm)
            | (bus.StatePreamble & nib_eq15)
            | (bus.StateJam & nib_eq7)
            | bus.StartDefer | bus.StartIPG | bus.StartFCS | bus.StartJam;

    inc_nib = bus.StateIPG | bus.StatePreamble | (|bus.StateData) | bus.StatePAD
            | bus.StateFCS | bus.StateJam | bus.StateBackOff
            | (bus.StateDefer & ~bus.ExDfrEn & bus.TxStartFrm);

    clr_byte = bus.StartBackoff | (bus.StateIdle & bus.TxStartFrm) | bus.PacketFinished_q;

    // Frame bytes saturate. Backoff steps wrap, because the backoff comparator depends on wrapping.
    inc_byte_sat  = bus.StateData[1] | ((bus.StatePAD | bus.StateFCS) & nib_cnt[0]);
    inc_byte_wrap = bus.StateBackOff & (&nib_cnt[6:0]);
  end

  eth_txcnt_cell #(.W(NIBCNT_W)) u_nib_cnt (
    .clk   (MTxClk),
    .rst_n (Reset_n),
    .clr   (clr_nib),
    .inc   (inc_nib),
    .sat   (1'b0),
    .cnt   (nib_cnt)
  );

  // A backoff increment overrides saturation: if it fires at 0xFFFF, the counter wraps to 0.
  eth_txcnt_cell #(.W(BYTECNT_W)) u_byte_cnt (
    .clk   (MTxClk),
    .rst_n (Reset_n),
    .clr   (clr_byte),
    .inc   (inc_byte_sat | inc_byte_wrap),
    .sat   (~inc_byte_wrap),
    .cnt   (byte_cnt)
  );

  assign min_thr = min_fl_thr(bus.MinFL, 16'(CRC_BYTES));

  assign bus.NibCnt         = nib_cnt;
  assign bus.ByteCnt        = byte_cnt;
  assign bus.NibCntEq7      = nib_eq7;
  assign bus.NibCntEq15     = nib_eq15;
  assign bus.NibbleMinFl    = ({1'b0, nib_cnt} >= min_thr);
  assign bus.ExcessiveDefer = (nib_cnt[13:0] == EXDFR_LIMIT) & ~bus.ExDfrEn;
  assign bus.MaxFrame       = (byte_cnt == bus.MaxFL) & ~bus.HugEn;

endmodule

// File: tb/tb_eth_txcounters_sn.sv
// Scoreboard bench for eth_txcounters_sn.
// Each scenario pushes its required counter/flag tuple before the clock edge.
// It pops and compares that tuple #1 after the edge.
`timescale 1ns/1ps
module tb_eth_txcounters_sn;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_txcounters_sn_if bus ();

  eth_txcounters_sn dut (
    .MTxClk  (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  // Packed expectation: nib, byte, flags {MaxFrame, ExcessiveDefer, NibbleMinFl, Eq15, Eq7}, care bits.
  typedef struct packed {
    logic [15:0] nib;
    logic [15:0] byt;
    logic [4:0]  flg;
    logic [6:0]  care;
  } exp_t;

  localparam logic [6:0] C_NIB   = 7'b1000000;
  localparam logic [6:0] C_BYTE  = 7'b0100000;
  localparam logic [6:0] C_FLAGS = 7'b0011111;
  localparam logic [6:0] C_MAXFR = 7'b0010000;
  localparam logic [6:0] C_EXDEF = 7'b0001000;
  localparam logic [6:0] C_ALL   = 7'b1111111;

  typedef struct packed {
    logic        rst;
    logic [1:0]  data;
    logic        sj;
    logic        pf;
    logic        idle;
    logic        tx;
    logic        sbk;
    logic [15:0] n;
    logic [15:0] b;
  } cp_t;

  // Clear-priority sequence, starting from NibCnt=ByteCnt=0, StateData=10 on every row.
  cp_t cp_tbl [13] = '{
    '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1},
    '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd2},
    '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd3},
    '{1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd4},
    '{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0},
    '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1},
    '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd2},
    '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0},
    '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1},
    '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd2},
    '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 16'd0},
    '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0},
    '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1}
  };

  int          checks = 0;
  int          errors = 0;
  exp_t        sb [$];
  exp_t        e;
  logic [36:0] m;
  logic [36:0] req;

  function automatic exp_t mk(input logic [15:0] n, input logic [15:0] b,
                              input logic [4:0] f, input logic [6:0] c);
    exp_t r;
    r.nib = n; r.byt = b; r.flg = f; r.care = c;
    return r;
  endfunction

  function automatic logic [36:0] care_mask(input logic [6:0] c);
    return {{16{c[6]}}, {16{c[5]}}, c[4:0]};
  endfunction

  function automatic logic [36:0] observed();
    return {bus.NibCnt, bus.ByteCnt, bus.MaxFrame, bus.ExcessiveDefer,
            bus.NibbleMinFl, bus.NibCntEq15, bus.NibCntEq7};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.StateIdle = 1'b0; bus.StateIPG = 1'b0; bus.StatePreamble = 1'b0;
    bus.StateData = 2'b00; bus.StatePAD = 1'b0; bus.StateFCS = 1'b0;
    bus.StateJam = 1'b0; bus.StateBackOff = 1'b0; bus.StateDefer = 1'b0;
    bus.StartDefer = 1'b0; bus.StartIPG = 1'b0; bus.StartFCS = 1'b0;
    bus.StartJam = 1'b0; bus.StartBackoff = 1'b0;
    bus.TxStartFrm = 1'b0; bus.PacketFinished_q = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.ExDfrEn = 1'b0; bus.HugEn = 1'b0;
    bus.MinFL = 16'd64; bus.MaxFL = 16'd1518;
    rst_n = 1'b0;
    tick();
    tick();
    sb.push_back(mk(16'd0, 16'd0, 5'b00000, C_ALL));
    e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
    if ((observed() & m) !== req) begin
      errors++;
      $display("FAIL reset observed=%h required=%h", observed() & m, req);
    end
    // MinFL at or below the FCS length makes the threshold 0, so NibbleMinFl is set at NibCnt=0.
    bus.MinFL = 16'd4; #1; checks++;
    if (bus.NibbleMinFl !== 1'b1) begin
      errors++; $display("FAIL minfl_le_crc observed=%b required=1", bus.NibbleMinFl);
    end
    bus.MinFL = 16'd5; #1; checks++;
    if (bus.NibbleMinFl !== 1'b0) begin
      errors++; $display("FAIL minfl_5 observed=%b required=0", bus.NibbleMinFl);
    end
    bus.MinFL = 16'd64;
    rst_n = 1'b1;
  endtask

  task automatic test_preamble();
    logic [15:0] n;
    bus.StatePreamble = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      n = (k == 16) ? 16'd0 : 16'(k);
      sb.push_back(mk(n, 16'd0, {3'b000, n[3:0] == 4'hF, n[2:0] == 3'h7}, C_ALL));
      tick();
      e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
      if ((observed() & m) !== req) begin
        errors++;
        $display("FAIL preamble k=%0d observed=%h required=%h", k, observed() & m, req);
      end
    end
    bus.StatePreamble = 1'b0;
  endtask

  task automatic test_jam();
    logic [15:0] n;
    bus.StateJam = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      n = (k == 8) ? 16'd0 : 16'(k);
      sb.push_back(mk(n, 16'd0, {4'b0000, n == 16'd7}, C_ALL));
      tick();
      e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
      if ((observed() & m) !== req) begin
        errors++;
        $display("FAIL jam k=%0d observed=%h required=%h", k, observed() & m, req);
      end
    end
    bus.StateJam = 1'b0;
  endtask

  task automatic test_min_frame();
    logic [15:0] n;
    bus.MinFL = 16'd64;
    for (int k = 1; k <= 125; k++) begin
      n = 16'(k);
      bus.StateData = (k > 100) ? 2'b00 : (n[0] ? 2'b01 : 2'b10);
      bus.StatePAD  = (k > 100);
      // A byte completes on every second nibble in both DATA and PAD, so ByteCnt = k/2.
      sb.push_back(mk(n, 16'(k / 2),
                      {2'b00, n >= 16'd119, n[3:0] == 4'hF, n[2:0] == 3'h7}, C_ALL));
      tick();
      e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
      if ((observed() & m) !== req) begin
        errors++;
        $display("FAIL min_frame k=%0d observed=%h required=%h", k, observed() & m, req);
      end
    end
    idle_inputs();
    bus.StateIdle = 1'b1; bus.PacketFinished_q = 1'b1;
    sb.push_back(mk(16'd0, 16'd0, 5'b00000, C_NIB | C_BYTE));
    tick();
    e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
    if ((observed() & m) !== req) begin
      errors++;
      $display("FAIL min_frame_clear observed=%h required=%h", observed() & m, req);
    end
    idle_inputs();
  endtask

  task automatic test_excessive_defer();
    bus.StateDefer = 1'b1; bus.TxStartFrm = 1'b1; bus.ExDfrEn = 1'b0;
    for (int k = 1; k <= 16'h17B7; k++) begin
      sb.push_back(mk(16'(k), 16'd0, {1'b0, k == 16'h17B7, 3'b000}, C_NIB | C_BYTE | C_EXDEF));
      tick();
      e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
      if ((observed() & m) !== req) begin
        errors++;
        $display("FAIL exdefer_count k=%0d observed=%h required=%h", k, observed() & m, req);
      end
    end
    // At the limit value, ExDfrEn=1 suppresses the flag at once; the next edge then clears NibCnt.
    bus.ExDfrEn = 1'b1; bus.TxStartFrm = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      if (k == 0) #1;
      else tick();
      sb.push_back(mk((k == 0) ? 16'h17B7 : 16'd0, 16'd0, 5'b00000, C_NIB | C_BYTE | C_EXDEF));
      e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
      if ((observed() & m) !== req) begin
        errors++;
        $display("FAIL exdefer_enabled k=%0d observed=%h required=%h", k, observed() & m, req);
      end
    end
    idle_inputs();
    bus.ExDfrEn = 1'b0;
  endtask

  task automatic test_max_frame();
    logic [15:0] b;
    bus.MaxFL = 16'd1518; bus.HugEn = 1'b0;
    bus.StateData = 2'b10;
    for (int k = 1; k <= 1520; k++) begin
      if (k > 1518) bus.StateData = 2'b00;
      b = (k > 1518) ? 16'd1518 : 16'(k);
      sb.push_back(mk(16'd0, b, {b == 16'd1518, 4'b0000}, C_BYTE | C_MAXFR));
      tick();
      e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
      if ((observed() & m) !== req) begin
        errors++;
        $display("FAIL max_frame k=%0d observed=%h required=%h", k, observed() & m, req);
      end
    end
    bus.HugEn = 1'b1; #1;
    sb.push_back(mk(16'd0, 16'd1518, 5'b00000, C_BYTE | C_MAXFR));
    e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
    if ((observed() & m) !== req) begin
      errors++;
      $display("FAIL max_frame_hugen observed=%h required=%h", observed() & m, req);
    end
    // With huge frames allowed, data bytes count up to 0xFFFF and hold there.
    bus.MaxFL = 16'hFFFF; bus.StateData = 2'b10;
    for (int k = 1519; k <= 65538; k++) begin
      b = (k > 65535) ? 16'hFFFF : 16'(k);
      sb.push_back(mk(16'd0, b, 5'b00000, C_BYTE | C_MAXFR));
      tick();
      e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
      if ((observed() & m) !== req) begin
        errors++;
        $display("FAIL saturate k=%0d observed=%h required=%h", k, observed() & m, req);
      end
    end
    bus.StateData = 2'b00; bus.HugEn = 1'b0; #1;
    sb.push_back(mk(16'd0, 16'hFFFF, 5'b10000, C_BYTE | C_MAXFR));
    e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
    if ((observed() & m) !== req) begin
      errors++;
      $display("FAIL max_frame_ffff observed=%h required=%h", observed() & m, req);
    end
    // In backoff, ByteCnt wraps from 0xFFFF to 0 on the edge after NibCnt[6:0] reaches 127.
    bus.StartJam = 1'b1;
    for (int k = 0; k <= 128; k++) begin
      sb.push_back(mk(16'(k), (k == 128) ? 16'd0 : 16'hFFFF, 5'b00000, C_NIB | C_BYTE));
      tick();
      bus.StartJam = 1'b0; bus.StateBackOff = 1'b1;
      e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
      if ((observed() & m) !== req) begin
        errors++;
        $display("FAIL backoff_wrap k=%0d observed=%h required=%h", k, observed() & m, req);
      end
    end
    idle_inputs();
    bus.MaxFL = 16'd1518;
  endtask

  task automatic test_clear_priority();
    bus.StateIdle = 1'b1; bus.PacketFinished_q = 1'b1;
    tick();
    idle_inputs();
    for (int r = 0; r < 13; r++) begin
      rst_n                = cp_tbl[r].rst;
      bus.StateData        = cp_tbl[r].data;
      bus.StartJam         = cp_tbl[r].sj;
      bus.PacketFinished_q = cp_tbl[r].pf;
      bus.StateIdle        = cp_tbl[r].idle;
      bus.TxStartFrm       = cp_tbl[r].tx;
      bus.StartBackoff     = cp_tbl[r].sbk;
      sb.push_back(mk(cp_tbl[r].n, cp_tbl[r].b, 5'b00000, C_NIB | C_BYTE));
      tick();
      e = sb.pop_front(); m = care_mask(e.care); req = {e.nib, e.byt, e.flg} & m; checks++;
      if ((observed() & m) !== req) begin
        errors++;
        $display("FAIL clear_priority row=%0d observed=%h required=%h", r, observed() & m, req);
      end
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_preamble();
    test_jam();
    test_min_frame();
    test_excessive_defer();
    test_max_frame();
    test_clear_priority();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
